// File: rtl/droute_sched.sv
// Route schedule sequencer: steps through a programmed table of inter-switch control words,
// holding each until its beat count completes. Optional watchdog: define DROUTE_SCHED_TIMEOUT_EN.
module droute_sched #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int BEAT_W      = 16,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [AW-1:0]     cfg_wr_addr,
  input  logic [54:0]       cfg_wr_data,
  input  logic [AW:0]       num_entries,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        mon_tvalid,
  input  logic [7:0]        mon_tready,
  output logic [17:0]       droute_switch_0,
  output logic [17:0]       droute_switch_1,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     cur_entry,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RUN   = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [54:0]       tbl [DEPTH];
  logic [54:0]       rd_word;
  logic [AW:0]       count;
  logic [GW-1:0]     gap_cnt;
  logic [BEAT_W-1:0] ent_beats;
  logic [2:0]        ent_sel;
  logic              hs;
  logic              last_beat;
  logic              last_entry;
  logic              gap_last;
  logic              start_acc;
  logic              abort_hit;
  logic              timeout;

  assign rd_word    = tbl[cur_entry];
  assign hs         = mon_tvalid[ent_sel] & mon_tready[ent_sel];
  assign last_beat  = hs && (beat_cnt == ent_beats - BEAT_W'(1));
  assign last_entry = ({1'b0, cur_entry} == count - 1'b1);
  assign gap_last   = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign start_acc  = (state == IDLE) && start && !abort;
  assign abort_hit  = (state != IDLE) && abort;

  // Table storage is never reset; entries survive rst and only change while idle.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && (state == IDLE) && (32'(cfg_wr_addr) < DEPTH))
      tbl[cfg_wr_addr] <= cfg_wr_data;
    if (state == FETCH) begin
      ent_beats <= BEAT_W'(rd_word[54:39]);
      ent_sel   <= rd_word[38:36];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start_acc) state_n = (num_entries == '0) ? DONE : FETCH;
      FETCH: state_n = (rd_word[54:39] == 16'd0) ? GAP : RUN;
      RUN: begin
        if (timeout)        state_n = IDLE;
        else if (last_beat) state_n = GAP;
      end
      GAP:   if (gap_last) state_n = last_entry ? DONE : FETCH;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      droute_switch_0 <= '0;
      droute_switch_1 <= '0;
      cur_entry       <= '0;
      beat_cnt        <= '0;
      count           <= '0;
      gap_cnt         <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);

      // Route words are applied only for the RUN span of a step; everywhere else they drain to zero.
      if ((state == FETCH) && (state_n == RUN)) begin
        droute_switch_0 <= rd_word[17:0];
        droute_switch_1 <= rd_word[35:18];
      end else if (state_n != RUN) begin
        droute_switch_0 <= '0;
        droute_switch_1 <= '0;
      end

      if ((state == RUN) && (state_n == RUN) && hs)
        beat_cnt <= beat_cnt + BEAT_W'(1);
      else if (state_n != RUN)
        beat_cnt <= '0;

      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

      if (start_acc) begin
        count     <= (num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_entries;
        cur_entry <= '0;
      end else if (abort_hit) begin
        cur_entry <= '0;
      end else if ((state == GAP) && (state_n == FETCH)) begin
        cur_entry <= cur_entry + 1'b1;
      end
    end
  end

`ifdef DROUTE_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  assign timeout = (state == RUN) && !hs && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog measures stall time since the last selected handshake (or since RUN was entered).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if ((state != RUN) || hs) wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + WD_W'(1);
      if (start_acc)    err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_droute_sched.sv
// Scoreboard bench for droute_sched: stimulus queues per-cycle expected outputs, a monitor
// compares them at the falling edge of the matching cycle.
module tb_droute_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_wr_addr = '0;
  logic [54:0] cfg_wr_data = '0;
  logic [4:0]  num_entries = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  mon_tvalid = '0;
  logic [7:0]  mon_tready = '0;
  logic [17:0] droute_switch_0;
  logic [17:0] droute_switch_1;
  logic        busy;
  logic        done;
  logic [3:0]  cur_entry;
  logic [15:0] beat_cnt;
  logic        err;

  droute_sched dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .num_entries(num_entries), .start(start), .abort(abort),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .droute_switch_0(droute_switch_0), .droute_switch_1(droute_switch_1),
    .busy(busy), .done(done), .cur_entry(cur_entry), .beat_cnt(beat_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    string       tag;
    logic [17:0] s0;
    logic [17:0] s1;
    logic        b;
    logic        d;
    logic [3:0]  e;
    logic [15:0] bc;
    bit          ce;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push_exp(int c, string tag, logic [17:0] s0, logic [17:0] s1,
                                   logic b, logic d, logic [3:0] e, logic [15:0] bc, bit ce);
    exp_t x;
    x.c = c; x.tag = tag; x.s0 = s0; x.s1 = s1; x.b = b; x.d = d; x.e = e; x.bc = bc; x.ce = ce;
    q.push_back(x);
  endfunction

  function automatic logic [54:0] mk(logic [15:0] beats, logic [2:0] sel,
                                     logic [17:0] sw1, logic [17:0] sw0);
    return {beats, sel, sw1, sw0};
  endfunction

  // Monitor: compare every queued expectation due in the current cycle.
  exp_t m;
  bit   bad;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      m = q.pop_front();
      checks++;
      bad = 1'b0;
      if (m.c != cyc) bad = 1'b1;
      if (droute_switch_0 !== m.s0) bad = 1'b1;
      if (droute_switch_1 !== m.s1) bad = 1'b1;
      if (busy !== m.b) bad = 1'b1;
      if (done !== m.d) bad = 1'b1;
      if (err !== 1'b0) bad = 1'b1;
      if (beat_cnt !== m.bc) bad = 1'b1;
      if (m.ce && cur_entry !== m.e) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): got sw0=%h sw1=%h busy=%b done=%b err=%b cur=%0d bc=%0d, want sw0=%h sw1=%h busy=%b done=%b err=0 cur=%0d bc=%0d",
                 m.tag, cyc, m.c, droute_switch_0, droute_switch_1, busy, done, err,
                 cur_entry, beat_cnt, m.s0, m.s1, m.b, m.d, m.e, m.bc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [54:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  int t0;

  initial begin
    // Power-on reset
    push_exp(1, "rst_hold1", 0, 0, 0, 0, 0, 0, 1);
    push_exp(2, "rst_hold2", 0, 0, 0, 0, 0, 0, 1);
    push_exp(3, "rst_idle", 0, 0, 0, 0, 0, 0, 1);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Single entry, back-to-back beats on output f
    wr(4'd0, mk(16'd4, 3'd5, 18'h0, 18'h00021));
    mon_tvalid = 8'h20; mon_tready = 8'h20; num_entries = 5'd1;
    t0 = cyc;
    push_exp(t0,   "s1_idle",  0, 0, 0, 0, 0, 0, 1);
    push_exp(t0+1, "s1_fetch", 0, 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++)
      push_exp(t0+2+k, $sformatf("s1_run%0d", k), 18'h00021, 0, 1, 0, 0, 16'(k), 1);
    push_exp(t0+6, "s1_gap0", 0, 0, 1, 0, 0, 0, 1);
    push_exp(t0+7, "s1_gap1", 0, 0, 1, 0, 0, 0, 1);
    push_exp(t0+8, "s1_done", 0, 0, 1, 1, 0, 0, 1);
    push_exp(t0+9, "s1_idle2", 0, 0, 0, 0, 0, 0, 1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    mon_tvalid = '0; mon_tready = '0;

    // Three entries (middle one empty) with backpressure and foreign handshakes
    wr(4'd0, mk(16'd3, 3'd0, 18'h00101, 18'h00011));
    wr(4'd1, mk(16'd0, 3'd2, 18'h00303, 18'h00003));
    wr(4'd2, mk(16'd2, 3'd2, 18'h00202, 18'h00022));
    num_entries = 5'd3;
    t0 = cyc;
    push_exp(t0,    "s2_r0",  0, 0, 0, 0, 0, 0, 0);
    push_exp(t0+1,  "s2_r1",  0, 0, 1, 0, 0, 0, 1);
    push_exp(t0+2,  "s2_r2",  18'h11, 18'h101, 1, 0, 0, 0, 1);
    push_exp(t0+3,  "s2_r3",  18'h11, 18'h101, 1, 0, 0, 1, 1);
    push_exp(t0+4,  "s2_r4",  18'h11, 18'h101, 1, 0, 0, 1, 1);
    push_exp(t0+5,  "s2_r5",  18'h11, 18'h101, 1, 0, 0, 2, 1);
    push_exp(t0+6,  "s2_r6",  0, 0, 1, 0, 0, 0, 1);
    push_exp(t0+7,  "s2_r7",  0, 0, 1, 0, 0, 0, 1);
    push_exp(t0+8,  "s2_r8",  0, 0, 1, 0, 1, 0, 1);
    push_exp(t0+9,  "s2_r9",  0, 0, 1, 0, 1, 0, 1);
    push_exp(t0+10, "s2_r10", 0, 0, 1, 0, 1, 0, 1);
    push_exp(t0+11, "s2_r11", 0, 0, 1, 0, 2, 0, 1);
    push_exp(t0+12, "s2_r12", 18'h22, 18'h202, 1, 0, 2, 0, 1);
    push_exp(t0+13, "s2_r13", 18'h22, 18'h202, 1, 0, 2, 1, 1);
    push_exp(t0+14, "s2_r14", 18'h22, 18'h202, 1, 0, 2, 1, 1);
    push_exp(t0+15, "s2_r15", 0, 0, 1, 0, 2, 0, 1);
    push_exp(t0+16, "s2_r16", 0, 0, 1, 0, 2, 0, 1);
    push_exp(t0+17, "s2_r17", 0, 0, 1, 1, 2, 0, 1);
    push_exp(t0+18, "s2_r18", 0, 0, 0, 0, 2, 0, 1);
    mon_tvalid = 8'h05;
    for (int r = 0; r <= 18; r++) begin
      start = (r == 0);
      mon_tready[0] = (r == 2 || r == 4 || r == 5 || (r >= 12 && r <= 14));
      mon_tready[2] = (r == 3 || r == 12 || r == 14);
      tick();
    end
    start = 1'b0; mon_tvalid = '0; mon_tready = '0;

    // Abort in RUN, then start+abort together while idle
    num_entries = 5'd1;
    mon_tvalid = 8'h01; mon_tready = 8'h01;
    t0 = cyc;
    push_exp(t0+2, "s3_run0", 18'h11, 18'h101, 1, 0, 0, 0, 1);
    push_exp(t0+3, "s3_run1", 18'h11, 18'h101, 1, 0, 0, 1, 1);
    push_exp(t0+4, "s3_abort", 0, 0, 0, 0, 0, 0, 1);
    push_exp(t0+5, "s3_nostart", 0, 0, 0, 0, 0, 0, 1);
    push_exp(t0+6, "s3_nodone", 0, 0, 0, 0, 0, 0, 1);
    for (int r = 0; r <= 6; r++) begin
      start = (r == 0 || r == 4);
      abort = (r == 3 || r == 4);
      tick();
    end
    start = 1'b0; abort = 1'b0; mon_tvalid = '0; mon_tready = '0;

    // Full table, write attempt while busy, clamped entry count
    for (int i = 0; i < 16; i++)
      wr(4'(i), mk(16'd1, 3'd0, 18'(i), 18'(32'h100 + i)));
    mon_tvalid = 8'h01; mon_tready = 8'h01; num_entries = 5'd17;
    t0 = cyc;
    for (int i = 0; i < 16; i++)
      push_exp(t0+2+4*i, $sformatf("s4_ent%0d", i), 18'(32'h100 + i), 18'(i), 1, 0, 4'(i), 0, 1);
    push_exp(t0+65, "s4_done", 0, 0, 1, 1, 15, 0, 1);
    push_exp(t0+66, "s4_idle", 0, 0, 0, 0, 15, 0, 1);
    for (int r = 0; r <= 66; r++) begin
      start = (r == 0);
      cfg_wr_en = (r == 2);
      cfg_wr_addr = 4'd0;
      cfg_wr_data = mk(16'd9, 3'd1, 18'h3FFFF, 18'h3FFFF);
      tick();
    end
    start = 1'b0; cfg_wr_en = 1'b0;
    num_entries = 5'd1;
    t0 = cyc;
    push_exp(t0+2, "s4_keep_run", 18'h100, 18'h0, 1, 0, 0, 0, 1);
    push_exp(t0+3, "s4_keep_gap", 0, 0, 1, 0, 0, 0, 1);
    push_exp(t0+5, "s4_keep_done", 0, 0, 1, 1, 0, 0, 1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    mon_tvalid = '0; mon_tready = '0;

    // Zero entries: straight to DONE
    num_entries = 5'd0;
    t0 = cyc;
    push_exp(t0+1, "s5_done", 0, 0, 1, 1, 0, 0, 0);
    push_exp(t0+2, "s5_idle", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();

    // Asynchronous reset in the middle of a RUN step
    wr(4'd0, mk(16'd5, 3'd0, 18'h0, 18'h00009));
    num_entries = 5'd1;
    t0 = cyc;
    push_exp(t0+2, "s6_run", 18'h9, 0, 1, 0, 0, 0, 1);
    push_exp(t0+3, "s6_rst_now", 0, 0, 0, 0, 0, 0, 1);
    push_exp(t0+4, "s6_rst_hold", 0, 0, 0, 0, 0, 0, 1);
    push_exp(t0+5, "s6_rel", 0, 0, 0, 0, 0, 0, 1);
    push_exp(t0+6, "s6_idle", 0, 0, 0, 0, 0, 0, 1);
    for (int r = 0; r <= 6; r++) begin
      start = (r == 0);
      rst = (r == 3 || r == 4);
      tick();
    end
    start = 1'b0; rst = 1'b0;
    repeat (3) tick();

    while (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cyc %0d never compared, final cyc %0d", m.tag, m.c, cyc);
    end
    if (errors != 0)
      $display("TEST FAILED");
    else
      $display("TEST PASSED");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/droute_sched.md
Name: droute_sched

Overview:
- Schedule sequencer for the data route fabric: holds a small table of routing steps and drives the two inter-switch control words (droute_switch_0, droute_switch_1) one step at a time.
- Each step stays active until a programmed number of AXI-Stream beats has completed on one selected route output.
- Between steps, both control words return to all-zero (no route) for a fixed gap, so the switches drain before the next route is applied.
- Sits beside the router at the fabric top level and is programmed by the host control path.

Parameters:
- DEPTH, 16, number of schedule entries
- AW, 4, entry address width (log2 DEPTH)
- BEAT_W, 16, beat-count width per entry
- GAP_CYCLES, 2, cycles of all-zero control between steps (must be at least 1)
- TIMEOUT_CYC, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cfg_wr_en  in  1  table write strobe
- cfg_wr_addr  in  AW  table write address
- cfg_wr_data  in  55  entry fields: {beats[54:39], mon_sel[38:36], sw1[35:18], sw0[17:0]}
- num_entries  in  AW+1  number of entries to run, sampled at start
- start  in  1  single-cycle run request
- abort  in  1  cancels the run
- mon_tvalid  in  8  tvalid of route outputs a..h (bit 0 = a)
- mon_tready  in  8  tready of route outputs a..h
- droute_switch_0  out  18  control word for inter-switch 0
- droute_switch_1  out  18  control word for inter-switch 1
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at the end of a run
- cur_entry  out  AW  index of the active entry
- beat_cnt  out  BEAT_W  beats counted in the current entry
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; the table is not cleared.
- Outputs are registered.
- Table write: when cfg_wr_en=1 in IDLE, write the entry at the clock edge. Writes while busy=1 are dropped. A write to an address >= DEPTH is ignored.
- num_entries is latched at start. Values above DEPTH are clamped to DEPTH.
- States: IDLE, FETCH, RUN, GAP, DONE.
- IDLE:
  - start=1 with latched count 0 -> DONE.
  - start=1 otherwise -> FETCH, with cur_entry=0 and err cleared.
  - start is ignored in every other state.
- FETCH (1 cycle):
  - Registered table read; control words held at 0.
  - Entry beats==0 -> GAP (entry skipped, control stays 0). Otherwise -> RUN.
- RUN:
  - Control words = sw0/sw1 of the entry.
  - beat_cnt increments on each cycle where mon_tvalid[mon_sel] & mon_tready[mon_sel] is high.
  - When a handshake occurs with beat_cnt==beats-1: next state GAP, control words 0 on the following cycle, beat_cnt reset to 0.
- Latency:
  - start at cycle T -> FETCH at T+1.
  - Control words valid at T+2.
  - After the final beat at cycle K, control is 0 at K+1.
- GAP:
  - Control words 0 for exactly GAP_CYCLES cycles.
  - Then, if cur_entry==count-1 -> DONE; else cur_entry+1 and -> FETCH.
- DONE (1 cycle): done=1, busy=1, then -> IDLE.
- abort:
  - In any non-IDLE state -> IDLE at the next edge.
  - Control words become 0, beat_cnt and cur_entry reset to 0, and done is not asserted.
  - abort wins over start in the same cycle.
  - abort in IDLE has no effect.
- Handshakes on non-selected outputs are ignored.
- beat_cnt counts only in RUN.
- The count does not wrap, because the step ends at beats-1.

Optional Feature:
- Macro: DROUTE_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts cycles spent in RUN with no selected-output handshake; it resets on each handshake and on entry to RUN.
  - When the watchdog reaches TIMEOUT_CYC: err=1 (sticky until the next start), control words go to 0, state -> IDLE, and done is not pulsed.
- Without the macro: no watchdog logic; err is tied to 0; RUN waits indefinitely.

Test Plan:
- Reset/idle: assert rst mid-RUN with entry 0 active (sw0=18'h0_0009) -> all outputs 0 immediately; state IDLE after rst falls.
- Single entry, back-to-back beats:
  - Setup: write entry 0 = {beats=4, mon_sel=5 (f), sw1=0, sw0=18'h00021}, num_entries=1, start at cycle 0.
  - Stimulus: mon f valid&ready held high.
  - Required: droute_switch_0=18'h00021 on cycles 2-5, 0 from cycle 6, done pulse at cycle 8 (GAP_CYCLES=2).
- Three entries with backpressure:
  - Setup: beats 3, 0, 2 on outputs a/c.
  - Stimulus: tready toggled 1-0-1.
  - Required: entry 1 is skipped with control 0; cur_entry runs 0,2; the total beat_cnt peaks are 2 and 1; a handshake on a non-selected output does not advance the count.
- Abort/start collision:
  - Stimulus: abort at the second RUN cycle of entry 0; next cycle, start and abort asserted together.
  - Required: IDLE, control 0, no done; start ignored.
- Busy writes and clamping:
  - Stimulus: cfg_wr_en during RUN to address 0; then a new run with num_entries=17.
  - Required: the original entry 0 content is used; 16 entries are run.
- Timeout (macro on, TIMEOUT_CYC=10):
  - Stimulus: start a run with no selected handshakes.
  - Required: err=1 at RUN cycle 10, control 0, IDLE, no done. The next start clears err.
